// File: rtl/compare_pkg.sv
// Result encoding and flag decoding shared by the comparator
// result tracker and anything that reads its status.
package compare_pkg;

  typedef enum logic [1:0] {
    RES_UNKNOWN = 2'b00,
    RES_LESS    = 2'b01,
    RES_EQUAL   = 2'b10,
    RES_GREATER = 2'b11
  } res_t;

  typedef struct packed {
    logic legal;
    res_t code;
  } flag_map_t;

  function automatic flag_map_t map_flags(
    input logic eq,
    input logic lt,
    input logic gt
  );
    flag_map_t m;
    m.legal = 1'b1;
    m.code  = RES_UNKNOWN;
    case ({eq, lt, gt})
      3'b100:  m.code = RES_EQUAL;
      3'b010:  m.code = RES_LESS;
      3'b001:  m.code = RES_GREATER;
      default: m.legal = 1'b0;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear.
// Clear takes priority over increment.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q
);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      q <= '0;
    end else if (inc && (q != {W{1'b1}})) begin
      q <= q + 1'b1;
    end
  end

endmodule

// File: rtl/compare_result_tracker.sv
// Debounces comparator flags into a committed result and
// counts commits per outcome.
module compare_result_tracker
  import compare_pkg::*;
#(
  parameter int STABLE_CYCLES = 3,
  parameter int CNT_W         = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic             eq_in,
  input  logic             lt_in,
  input  logic             gt_in,
  input  logic             clr_cnt,
  output logic [1:0]       state_out,
  output logic             change_pulse,
  output logic             err_pulse,
  output logic [CNT_W-1:0] cnt_less,
  output logic [CNT_W-1:0] cnt_equal,
  output logic [CNT_W-1:0] cnt_greater
);

  localparam logic [3:0] STABLE = 4'(STABLE_CYCLES);

  res_t       state, state_nxt;
  res_t       cand, cand_nxt;
  logic [3:0] run, run_nxt;
  logic       change_nxt;
  logic       err_nxt;
  logic       commit;
  flag_map_t  smp;

  assign smp = map_flags(eq_in, lt_in, gt_in);

  always_comb begin
    state_nxt  = state;
    cand_nxt   = cand;
    run_nxt    = run;
    change_nxt = 1'b0;
    err_nxt    = 1'b0;
    commit     = 1'b0;
    if (in_valid) begin
      if (smp.legal) begin
        if (smp.code == cand) begin
          run_nxt = (run >= STABLE) ? STABLE : run + 4'd1;
        end else begin
          cand_nxt = smp.code;
          run_nxt  = 4'd1;
        end
        // cand is never UNKNOWN here, so a commit cannot reach UNKNOWN
        if (run_nxt == STABLE && cand_nxt != state) begin
          commit     = 1'b1;
          state_nxt  = cand_nxt;
          change_nxt = 1'b1;
        end
      end else begin
        err_nxt  = 1'b1;
        cand_nxt = RES_UNKNOWN;
        run_nxt  = 4'd0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= RES_UNKNOWN;
      cand         <= RES_UNKNOWN;
      run          <= 4'd0;
      change_pulse <= 1'b0;
      err_pulse    <= 1'b0;
    end else begin
      state        <= state_nxt;
      cand         <= cand_nxt;
      run          <= run_nxt;
      change_pulse <= change_nxt;
      err_pulse    <= err_nxt;
    end
  end

  assign state_out = state;

  sat_counter #(.W(CNT_W)) u_cnt_less (
    .clk (clk),
    .rst (rst),
    .clr (clr_cnt),
    .inc (commit && state_nxt == RES_LESS),
    .q   (cnt_less)
  );

  sat_counter #(.W(CNT_W)) u_cnt_equal (
    .clk (clk),
    .rst (rst),
    .clr (clr_cnt),
    .inc (commit && state_nxt == RES_EQUAL),
    .q   (cnt_equal)
  );

  sat_counter #(.W(CNT_W)) u_cnt_greater (
    .clk (clk),
    .rst (rst),
    .clr (clr_cnt),
    .inc (commit && state_nxt == RES_GREATER),
    .q   (cnt_greater)
  );

endmodule

// File: tb/tb_compare_result_tracker.sv
// Directed bench for compare_result_tracker: a wide-counter
// instance plus a 2-bit-counter instance on shared stimulus.
module tb_compare_result_tracker;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       eq_in, lt_in, gt_in;
  logic       clr_cnt;
  logic [1:0] state_out, state_out2;
  logic       change_pulse, change_pulse2;
  logic       err_pulse, err_pulse2;
  logic [7:0] cnt_less, cnt_equal, cnt_greater;
  logic [1:0] cnt_less2, cnt_equal2, cnt_greater2;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  compare_result_tracker #(.STABLE_CYCLES(3), .CNT_W(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .eq_in        (eq_in),
    .lt_in        (lt_in),
    .gt_in        (gt_in),
    .clr_cnt      (clr_cnt),
    .state_out    (state_out),
    .change_pulse (change_pulse),
    .err_pulse    (err_pulse),
    .cnt_less     (cnt_less),
    .cnt_equal    (cnt_equal),
    .cnt_greater  (cnt_greater)
  );

  compare_result_tracker #(.STABLE_CYCLES(3), .CNT_W(2)) dut2 (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .eq_in        (eq_in),
    .lt_in        (lt_in),
    .gt_in        (gt_in),
    .clr_cnt      (clr_cnt),
    .state_out    (state_out2),
    .change_pulse (change_pulse2),
    .err_pulse    (err_pulse2),
    .cnt_less     (cnt_less2),
    .cnt_equal    (cnt_equal2),
    .cnt_greater  (cnt_greater2)
  );

  task automatic chk(input string tag, input logic [7:0] obs,
                     input logic [7:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // apply one sample, then look #1 after the edge
  task automatic step(input logic v, input logic e, input logic l,
                      input logic g, input logic c = 1'b0);
    in_valid = v;
    eq_in    = e;
    lt_in    = l;
    gt_in    = g;
    clr_cnt  = c;
    @(posedge clk);
    #1;
    clr_cnt  = 1'b0;
  endtask

  task automatic lt3();
    step(1, 0, 1, 0);
    step(1, 0, 1, 0);
    step(1, 0, 1, 0);
  endtask

  task automatic eq3();
    step(1, 1, 0, 0);
    step(1, 1, 0, 0);
    step(1, 1, 0, 0);
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    eq_in = 1'b0;
    lt_in = 1'b0;
    gt_in = 1'b0;
    clr_cnt = 1'b0;

    // reset with flags toggling
    step(1, 0, 1, 0);
    step(1, 1, 1, 0);
    rst = 1'b0;
    chk("rst_state", 8'(state_out), 8'h0);
    chk("rst_change", 8'(change_pulse), 8'h0);
    chk("rst_err", 8'(err_pulse), 8'h0);
    chk("rst_cnt_less", cnt_less, 8'h0);
    chk("rst_cnt_equal", cnt_equal, 8'h0);
    chk("rst_cnt_greater", cnt_greater, 8'h0);

    // basic commit
    step(1, 0, 1, 0);
    chk("basic_s1_state", 8'(state_out), 8'h0);
    step(1, 0, 1, 0);
    chk("basic_s2_state", 8'(state_out), 8'h0);
    chk("basic_s2_change", 8'(change_pulse), 8'h0);
    step(1, 0, 1, 0);
    chk("basic_s3_state", 8'(state_out), 8'h1);
    chk("basic_s3_change", 8'(change_pulse), 8'h1);
    chk("basic_s3_cnt", cnt_less, 8'h1);
    step(1, 0, 1, 0);
    chk("basic_s4_change", 8'(change_pulse), 8'h0);
    step(1, 0, 1, 0);
    step(1, 0, 1, 0);
    chk("basic_s6_change", 8'(change_pulse), 8'h0);
    chk("basic_s6_cnt", cnt_less, 8'h1);
    chk("basic_s6_state", 8'(state_out), 8'h1);

    // interrupted run: lt,lt,gt,gt,gt
    step(1, 0, 1, 0);
    step(1, 0, 1, 0);
    step(1, 0, 0, 1);
    step(1, 0, 0, 1);
    chk("intr_s4_state", 8'(state_out), 8'h1);
    chk("intr_s4_change", 8'(change_pulse), 8'h0);
    step(1, 0, 0, 1);
    chk("intr_s5_state", 8'(state_out), 8'h3);
    chk("intr_s5_change", 8'(change_pulse), 8'h1);
    chk("intr_s5_cnt_g", cnt_greater, 8'h1);
    chk("intr_s5_cnt_l", cnt_less, 8'h1);

    // valid gaps do not break a run
    step(1, 0, 1, 0);
    step(0, 0, 0, 0);
    step(0, 1, 1, 1);
    chk("gap_invalid_err", 8'(err_pulse), 8'h0);
    step(1, 0, 1, 0);
    chk("gap_s2_state", 8'(state_out), 8'h3);
    step(1, 0, 1, 0);
    chk("gap_s3_state", 8'(state_out), 8'h1);
    chk("gap_s3_change", 8'(change_pulse), 8'h1);
    chk("gap_s3_cnt", cnt_less, 8'h2);

    // illegal sample restarts the run
    step(1, 0, 0, 1);
    step(1, 0, 0, 1);
    step(1, 0, 0, 1);
    chk("ill_pre_state", 8'(state_out), 8'h3);
    chk("ill_pre_cnt_g", cnt_greater, 8'h2);
    step(1, 0, 1, 0);
    step(1, 0, 1, 0);
    step(1, 1, 1, 0);
    chk("ill_err", 8'(err_pulse), 8'h1);
    chk("ill_state", 8'(state_out), 8'h3);
    step(1, 0, 0, 0);
    chk("ill_none_err", 8'(err_pulse), 8'h1);
    step(1, 0, 1, 0);
    chk("ill_err_clear", 8'(err_pulse), 8'h0);
    step(1, 0, 1, 0);
    chk("ill_l2_state", 8'(state_out), 8'h3);
    chk("ill_l2_change", 8'(change_pulse), 8'h0);
    step(1, 0, 1, 0);
    chk("ill_l3_state", 8'(state_out), 8'h1);
    chk("ill_l3_cnt", cnt_less, 8'h3);
    chk("ill_l3_cnt2", 8'(cnt_less2), 8'h3);

    // saturation on the 2-bit instance
    eq3();
    chk("sat_e1_cnt2", 8'(cnt_equal2), 8'h1);
    lt3();
    chk("sat_l_cnt2_hold", 8'(cnt_less2), 8'h3);
    chk("sat_l_cnt", cnt_less, 8'h4);
    eq3();
    lt3();
    eq3();
    chk("sat_e3_cnt2", 8'(cnt_equal2), 8'h3);
    lt3();
    eq3();
    chk("sat_e4_cnt2", 8'(cnt_equal2), 8'h3);
    chk("sat_e4_change2", 8'(change_pulse2), 8'h1);
    chk("sat_e4_cnt", cnt_equal, 8'h4);
    chk("sat_l_final", cnt_less, 8'h6);

    // clear coinciding with a commit
    step(1, 0, 1, 0);
    step(1, 0, 1, 0);
    step(1, 0, 1, 0, 1'b1);
    chk("clr_state", 8'(state_out2), 8'h1);
    chk("clr_change", 8'(change_pulse2), 8'h1);
    chk("clr_less2", 8'(cnt_less2), 8'h0);
    chk("clr_equal2", 8'(cnt_equal2), 8'h0);
    chk("clr_greater2", 8'(cnt_greater2), 8'h0);
    chk("clr_less", cnt_less, 8'h0);
    chk("clr_greater", cnt_greater, 8'h0);

    // reset mid-run discards the partial run
    step(1, 0, 0, 1);
    step(1, 0, 0, 1);
    rst = 1'b1;
    step(1, 0, 0, 1);
    rst = 1'b0;
    chk("mid_rst_state", 8'(state_out), 8'h0);
    chk("mid_rst_change", 8'(change_pulse), 8'h0);
    step(1, 0, 0, 1);
    step(1, 0, 0, 1);
    chk("mid_rst_s2_state", 8'(state_out), 8'h0);
    step(1, 0, 0, 1);
    chk("mid_rst_s3_state", 8'(state_out), 8'h3);
    chk("mid_rst_s3_cnt", cnt_greater, 8'h1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
